// File: rtl/modn_count.sv
// rtl/modn_count.sv - cascadable modulo-MOD up/down counter stage with guarded load
//
// Purpose:
//   One digit stage of a counter chain. It counts modulo MOD, up or down. It also
//   supports a synchronous clear and a parallel load. A load with an out-of-range
//   value is rejected and sets a sticky error flag. To cascade stages, drive the en
//   of stage k+1 from the inc_nxt of stage k. The carry is combinational, so every
//   stage in the chain steps on the same clock edge.
//
// Ports:
//   clk      in   1      rising-edge system clock
//   rst      in   1      asynchronous active-high reset (cnt=RESET_VAL, ld_err=0)
//   en       in   1      count enable (usually inc_nxt of the stage below)
//   up_dn    in   1      1 = count up, 0 = count down
//   clr      in   1      synchronous clear; highest priority
//   ld       in   1      synchronous load of ld_val
//   ld_val   in   WIDTH  value to load
//   cnt      out  WIDTH  registered count, 0..MOD-1
//   inc_nxt  out  1      carry/borrow to the next stage (combinational)
//   tc       out  1      terminal count for the current direction
//   ld_err   out  1      sticky: a load with ld_val >= MOD was rejected

module modn_count #(
  parameter int WIDTH     = 4,
  parameter int MOD       = 3,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] cnt,
  output logic             inc_nxt,
  output logic             tc,
  output logic             ld_err
);

  if (MOD < 2) begin : g_chk_mod_min
    $fatal(1, "modn_count: MOD must be >= 2");
  end
  if (64'(MOD) > (64'd1 << WIDTH)) begin : g_chk_mod_max
    $fatal(1, "modn_count: MOD must be <= 2**WIDTH");
  end
  if (RESET_VAL >= MOD || RESET_VAL < 0) begin : g_chk_reset_val
    $fatal(1, "modn_count: RESET_VAL must be in 0..MOD-1");
  end

  // Range comparisons are done one bit wider, since the modulus can equal 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic             ld_ok;
  logic             cnt_ok;
  logic [WIDTH-1:0] step_val;

  assign ld_ok  = {1'b0, ld_val} < MOD_W;
  assign cnt_ok = {1'b0, cnt} < MOD_W;

  assign tc      = up_dn ? (cnt == MAX_V) : (cnt == '0);
  assign inc_nxt = en & tc & ~clr & ~ld;

  // Next value for an enabled count step. An out-of-range count can only come
  // from an upset. It recovers to 0 in either direction instead of walking
  // further out of range.
  always_comb begin
    step_val = '0;
    if (!cnt_ok) begin
      step_val = '0;
    end else if (up_dn) begin
      step_val = (cnt == MAX_V) ? '0 : cnt + WIDTH'(1);
    end else begin
      step_val = (cnt == '0) ? MAX_V : cnt - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= RST_V;
      ld_err <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      ld_err <= 1'b0;
    end else if (ld) begin
      if (ld_ok) begin
        cnt <= ld_val;
      end else begin
        ld_err <= 1'b1;
      end
    end else if (en) begin
      cnt <= step_val;
    end
  end

endmodule

// File: tb/tb_modn_count.sv
// tb/tb_modn_count.sv - self-checking bench for modn_count
module tb_modn_count;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic       a_en = 0, a_up = 0, a_clr = 0, a_ld = 0;
  logic [3:0] a_ldv = '0, a_cnt;
  logic       a_inc, a_tc, a_err;

  logic       b_en = 0, b_up = 0, b_clr = 0, b_ld = 0;
  logic [3:0] b_ldv = '0, b_cnt;
  logic       b_inc, b_tc, b_err;

  logic       e_en = 0, e_up = 0, e_clr = 0, e_ld = 0;
  logic [5:0] e_ldv = '0, e_cnt;
  logic       e_inc, e_tc, e_err;

  logic       c_en = 0;
  logic [3:0] c0_cnt;
  logic       c0_inc, c0_tc, c0_err;
  logic [2:0] c1_cnt;
  logic       c1_inc, c1_tc, c1_err;

  int total  = 0;
  int passed = 0;
  int exp_q[$];

  modn_count #(.WIDTH(4), .MOD(3), .RESET_VAL(0)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .up_dn(a_up), .clr(a_clr), .ld(a_ld),
    .ld_val(a_ldv), .cnt(a_cnt), .inc_nxt(a_inc), .tc(a_tc), .ld_err(a_err));

  modn_count #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .up_dn(b_up), .clr(b_clr), .ld(b_ld),
    .ld_val(b_ldv), .cnt(b_cnt), .inc_nxt(b_inc), .tc(b_tc), .ld_err(b_err));

  modn_count #(.WIDTH(6), .MOD(60), .RESET_VAL(0)) u_e (
    .clk(clk), .rst(rst), .en(e_en), .up_dn(e_up), .clr(e_clr), .ld(e_ld),
    .ld_val(e_ldv), .cnt(e_cnt), .inc_nxt(e_inc), .tc(e_tc), .ld_err(e_err));

  modn_count #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) u_c0 (
    .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .clr(1'b0), .ld(1'b0),
    .ld_val(4'd0), .cnt(c0_cnt), .inc_nxt(c0_inc), .tc(c0_tc), .ld_err(c0_err));

  modn_count #(.WIDTH(3), .MOD(6), .RESET_VAL(0)) u_c1 (
    .clk(clk), .rst(rst), .en(c0_inc), .up_dn(1'b1), .clr(1'b0), .ld(1'b0),
    .ld_val(3'd0), .cnt(c1_cnt), .inc_nxt(c1_inc), .tc(c1_tc), .ld_err(c1_err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (a_cnt !== 4'd0) $display("FAIL reset_a_cnt: got %0d expected 0", a_cnt); else passed++;
    total++; if (b_cnt !== 4'd0) $display("FAIL reset_b_cnt: got %0d expected 0", b_cnt); else passed++;
    total++; if (e_err !== 1'b0) $display("FAIL reset_e_err: got %0d expected 0", e_err); else passed++;
    total++; if ({c1_cnt, c0_cnt} !== 7'd0) $display("FAIL reset_casc: got %0d expected 0", {c1_cnt, c0_cnt}); else passed++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_mod3_up();
    int m = 0;
    int pulses = 0;
    int e;
    a_en = 1; a_up = 1;
    for (int i = 0; i < 7; i++) begin
      #1;
      total++;
      if (a_inc !== (m == 2)) $display("FAIL mod3_inc[%0d]: got %0d expected %0d", i, a_inc, (m == 2));
      else passed++;
      if (a_inc === 1'b1) pulses++;
      exp_q.push_back((m + 1) % 3);
      m = (m + 1) % 3;
      tick();
      e = exp_q.pop_front();
      total++;
      if (a_cnt !== 4'(e)) $display("FAIL mod3_cnt[%0d]: got %0d expected %0d", i, a_cnt, e);
      else passed++;
    end
    total++; if (pulses != 2) $display("FAIL mod3_pulses: got %0d expected 2", pulses); else passed++;
    a_en = 0;
  endtask

  task automatic test_mod10_down();
    int m = 0;
    int e;
    b_en = 1; b_up = 0;
    for (int i = 0; i < 11; i++) begin
      #1;
      total++;
      if (b_inc !== (m == 0)) $display("FAIL mod10_inc[%0d]: got %0d expected %0d", i, b_inc, (m == 0));
      else passed++;
      m = (m == 0) ? 9 : m - 1;
      exp_q.push_back(m);
      tick();
      e = exp_q.pop_front();
      total++;
      if (b_cnt !== 4'(e)) $display("FAIL mod10_cnt[%0d]: got %0d expected %0d", i, b_cnt, e);
      else passed++;
    end
    b_en = 0;
  endtask

  task automatic test_load_err();
    int e;
    e_ld = 1; e_ldv = 6'd59; exp_q.push_back(59); tick(); e = exp_q.pop_front();
    total++; if (e_cnt !== 6'(e)) $display("FAIL ld59_cnt: got %0d expected %0d", e_cnt, e); else passed++;
    total++; if (e_err !== 1'b0) $display("FAIL ld59_err: got %0d expected 0", e_err); else passed++;
    e_ldv = 6'd60; exp_q.push_back(59); tick(); e = exp_q.pop_front();
    total++; if (e_cnt !== 6'(e)) $display("FAIL ld60_cnt: got %0d expected %0d", e_cnt, e); else passed++;
    total++; if (e_err !== 1'b1) $display("FAIL ld60_err: got %0d expected 1", e_err); else passed++;
    e_ldv = 6'd30; exp_q.push_back(30); tick(); e = exp_q.pop_front();
    total++; if (e_cnt !== 6'(e)) $display("FAIL ld30_cnt: got %0d expected %0d", e_cnt, e); else passed++;
    total++; if (e_err !== 1'b1) $display("FAIL ld30_err_sticky: got %0d expected 1", e_err); else passed++;
    e_ld = 0; e_clr = 1; exp_q.push_back(0); tick(); e = exp_q.pop_front();
    total++; if (e_cnt !== 6'(e)) $display("FAIL clr_cnt: got %0d expected %0d", e_cnt, e); else passed++;
    total++; if (e_err !== 1'b0) $display("FAIL clr_err: got %0d expected 0", e_err); else passed++;
    e_clr = 0;
  endtask

  task automatic test_priority();
    int e;
    b_up = 1; b_en = 1; #1;
    total++; if (b_inc !== 1'b1) $display("FAIL prio_en_only_inc: got %0d expected 1", b_inc); else passed++;
    b_clr = 1; b_ld = 1; b_ldv = 4'd4; #1;
    total++; if (b_inc !== 1'b0) $display("FAIL prio_clr_inc: got %0d expected 0", b_inc); else passed++;
    exp_q.push_back(0); tick(); e = exp_q.pop_front();
    total++; if (b_cnt !== 4'(e)) $display("FAIL prio_clr_cnt: got %0d expected %0d", b_cnt, e); else passed++;
    b_clr = 0; b_en = 0; b_ldv = 4'd9; exp_q.push_back(9); tick(); e = exp_q.pop_front();
    total++; if (b_cnt !== 4'(e)) $display("FAIL prio_ld9_cnt: got %0d expected %0d", b_cnt, e); else passed++;
    b_en = 1; b_ldv = 4'd3; #1;
    total++; if (b_inc !== 1'b0) $display("FAIL prio_ld_inc: got %0d expected 0", b_inc); else passed++;
    exp_q.push_back(3); tick(); e = exp_q.pop_front();
    total++; if (b_cnt !== 4'(e)) $display("FAIL prio_ld_cnt: got %0d expected %0d", b_cnt, e); else passed++;
    b_en = 0; b_ldv = 4'd0; tick();
    b_ld = 0; b_en = 1; b_up = 0; #1;
    total++; if ({b_tc, b_inc} !== 2'b11) $display("FAIL dir_down_tc_inc: got %0d expected 3", {b_tc, b_inc}); else passed++;
    b_up = 1; #1;
    total++; if ({b_tc, b_inc} !== 2'b00) $display("FAIL dir_up_tc_inc: got %0d expected 0", {b_tc, b_inc}); else passed++;
    exp_q.push_back(1); tick(); e = exp_q.pop_front();
    total++; if (b_cnt !== 4'(e)) $display("FAIL dir_up_cnt: got %0d expected %0d", b_cnt, e); else passed++;
    b_en = 0;
  endtask

  task automatic test_cascade();
    int e;
    int got;
    c_en = 1;
    for (int k = 1; k <= 60; k++) begin
      #1;
      total++;
      if (c1_inc !== (k == 60)) $display("FAIL casc_c1_inc[%0d]: got %0d expected %0d", k, c1_inc, (k == 60));
      else passed++;
      exp_q.push_back(((k / 10) % 6) * 16 + (k % 10));
      tick();
      e = exp_q.pop_front();
      got = int'(c1_cnt) * 16 + int'(c0_cnt);
      total++;
      if (got != e) $display("FAIL casc_cnt[%0d]: got 0x%0h expected 0x%0h", k, got, e);
      else passed++;
    end
    c_en = 0;
  endtask

  task automatic test_async_reset();
    int e;
    b_ld = 1; b_ldv = 4'd12; tick();
    total++; if (b_err !== 1'b1) $display("FAIL ar_pre_err: got %0d expected 1", b_err); else passed++;
    b_ldv = 4'd5; exp_q.push_back(5); tick(); e = exp_q.pop_front();
    total++; if (b_cnt !== 4'(e)) $display("FAIL ar_pre_cnt: got %0d expected %0d", b_cnt, e); else passed++;
    b_ld = 0;
    #3;
    b_en = 0; rst = 1; #1;
    total++; if (b_cnt !== 4'd0) $display("FAIL ar_async_cnt: got %0d expected 0", b_cnt); else passed++;
    total++; if (b_err !== 1'b0) $display("FAIL ar_async_err: got %0d expected 0", b_err); else passed++;
    total++; if (b_inc !== 1'b0) $display("FAIL ar_async_inc: got %0d expected 0", b_inc); else passed++;
    tick();
    total++; if ({b_cnt, b_inc} !== 5'd0) $display("FAIL ar_held: got %0d expected 0", {b_cnt, b_inc}); else passed++;
    rst = 0; b_en = 1; b_up = 1; exp_q.push_back(1); tick(); e = exp_q.pop_front();
    total++; if (b_cnt !== 4'(e)) $display("FAIL ar_resume_cnt: got %0d expected %0d", b_cnt, e); else passed++;
    b_en = 0;
  endtask

  initial begin
    test_reset();
    test_mod3_up();
    test_mod10_down();
    test_load_err();
    test_priority();
    test_cascade();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
